// File: rtl/mem_bus_if.sv
// Ready-handshaked word data bus between the MEM-stage controller (master)
// and the data memory or bus fabric (slave).
interface mem_bus_if;
  logic [31:0] busAddress;
  logic [31:0] busWriteData;
  logic        busRead;
  logic        busWrite;
  logic        busReady;
  logic [31:0] busReadData;

  modport master (
    output busAddress, busWriteData, busRead, busWrite,
    input  busReady, busReadData
  );

  modport slave (
    input  busAddress, busWriteData, busRead, busWrite,
    output busReady, busReadData
  );
endinterface

// File: rtl/memory_access_stage.sv
// MEM-stage controller: one word transaction per instruction on a ready-handshaked bus.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (reject misaligned accesses).
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      memAluResult,
  input  logic [31:0]      memMemoryWriteData,
  input  logic             memMemWrite,
  input  logic             memMemRead,
  mem_bus_if.master        bus,
  output logic [31:0]      memReadData,
  output logic             memStall,
  output logic             memBusError,
  output logic             memMisaligned
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            w_req;
  logic            w_misaligned;
  logic [31:0]     w_capAddr;

  assign w_req = memMemRead | memMemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misaligned = (memAluResult[1:0] != 2'b00);
  assign w_capAddr    = memAluResult;
`else
  assign w_misaligned = 1'b0;
  assign w_capAddr    = memAluResult & 32'hFFFF_FFFC;
`endif

  // DONE deliberately drops the stall so the barrier advances without re-issuing.
  always_comb begin
    memStall = (r_state == ACCESS) || ((r_state == IDLE) && w_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_count          <= '0;
      bus.busAddress   <= '0;
      bus.busWriteData <= '0;
      bus.busRead      <= 1'b0;
      bus.busWrite     <= 1'b0;
      memReadData      <= '0;
      memBusError      <= 1'b0;
      memMisaligned    <= 1'b0;
    end else begin
      memBusError   <= 1'b0;
      memMisaligned <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_misaligned) begin
              memMisaligned <= 1'b1;
              r_state       <= DONE;
            end else begin
              bus.busAddress   <= w_capAddr;
              bus.busWriteData <= memMemoryWriteData;
              bus.busWrite     <= memMemWrite;
              bus.busRead      <= ~memMemWrite;
              r_count          <= '0;
              r_state          <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (bus.busReady) begin
            if (bus.busRead) memReadData <= bus.busReadData;
            bus.busRead  <= 1'b0;
            bus.busWrite <= 1'b0;
            r_state      <= DONE;
          end else if (r_count == LAST_CNT) begin
            if (bus.busRead) memReadData <= '0;
            memBusError  <= 1'b1;
            bus.busRead  <= 1'b0;
            bus.busWrite <= 1'b0;
            r_state      <= DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

MEM-stage controller sitting directly downstream of the EX/MEM pipeline barrier. It takes the latched ALU result (address), store data and memory control bits, runs one word-sized transaction on a ready-handshaked data bus, and returns registered load data to the MEM/WB barrier. While a transaction is in flight it raises `memStall`, which the hazard logic routes to the `dontUpdate` inputs of the upstream barriers.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles without `busReady` before the transaction is aborted; legal range 2..255.
- `clk`  in  1  pipeline clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `memAluResult`  in  32  byte address from EX/MEM barrier
- `memMemoryWriteData`  in  32  store data from EX/MEM barrier
- `memMemWrite`  in  1  store request
- `memMemRead`  in  1  load request
- `busReady`  in  1  bus completion strobe, sampled only in ACCESS
- `busReadData`  in  32  bus load data, valid when `busReady`=1
- `busAddress`  out  32  registered transaction address
- `busWriteData`  out  32  registered store data
- `busRead`  out  1  load request, held high through ACCESS
- `busWrite`  out  1  store request, held high through ACCESS
- `memReadData`  out  32  registered load result to MEM/WB barrier
- `memStall`  out  1  combinational stall to hazard unit
- `memBusError`  out  1  one-cycle pulse: transaction timed out
- `memMisaligned`  out  1  one-cycle pulse: misaligned access rejected

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request (`memMemRead`=`memMemWrite`=0): stay; `memStall`=0.
- IDLE, request: capture address and store data into bus registers, set `busWrite` if `memMemWrite` else `busRead`; clear timeout counter; go ACCESS. `memStall`=1 this cycle.
- Both request bits set: treated as store; load ignored.
- ACCESS: `memStall`=1; counter increments each cycle. On `busReady`=1: for loads, `memReadData` <= `busReadData`; for stores, `memReadData` unchanged; go DONE.
- ACCESS, counter = `TIMEOUT_CYCLES`-1 and `busReady`=0: abort; loads write `memReadData` <= 0; `memBusError`=1 during the following DONE cycle; go DONE.
- `busReady` and timeout on the same cycle: `busReady` wins, no error.
- DONE: `busRead`/`busWrite` low, `memStall`=0 so the barrier advances; go IDLE unconditionally. This cycle never starts a new transaction, so the same held instruction is never issued twice.
- `memReadData` holds its value until the next completed or aborted load.
- Counter width: ceil(log2(`TIMEOUT_CYCLES`)) bits; no wrap within a transaction.

## Timing
- Reset values: state IDLE, `busAddress`=0, `busWriteData`=0, `busRead`=0, `busWrite`=0, `memReadData`=0, `memBusError`=0, `memMisaligned`=0, counter 0.
- Reset mid-ACCESS: request dropped at that edge; no DONE cycle, no error pulse.
- Zero-wait access (`busReady` in first ACCESS cycle): IDLE, ACCESS, DONE; `memStall` high 2 cycles; `memReadData` valid in DONE.
- N wait cycles add N stall cycles.
- Timeout: `memStall` high 1 + `TIMEOUT_CYCLES` cycles.
- Bus outputs are purely registered; `memStall` is the only combinational output.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined: a request with `memAluResult[1:0]`≠0 skips ACCESS. It goes IDLE to DONE with no bus activity, `memReadData` unchanged, and `memMisaligned`=1 during DONE. `memStall` is high for 1 cycle.
- Undefined: `busAddress[1:0]` forced to 0 on capture; the access proceeds normally; `memMisaligned` tied 0.

## Test plan
- Load at 0x100, `busReady` in first ACCESS cycle with 0xDEADBEEF: `busRead` high 1 cycle, `busAddress`=0x100, `memStall` high 2 cycles, `memReadData`=0xDEADBEEF in DONE.
- Store 0x12345678 to 0x40, `busReady` after 3 wait cycles: `busWrite` high 4 cycles, `busWriteData`=0x12345678, `memStall` high 5 cycles, `memReadData` unchanged.
- Load with `busReady` never asserted, `TIMEOUT_CYCLES`=16: `memStall` high 17 cycles, `memBusError` pulses once, `memReadData`=0.
- Back-to-back loads held by the barrier: exactly one `busRead` assertion per instruction, and one DONE cycle between them.
- `rst` asserted in the 2nd ACCESS cycle: next cycle all outputs at reset values, no `memBusError` pulse.
- Load at 0x102: with `MEM_MISALIGN_CHECK_EN`, no `busRead` and `memMisaligned` pulses. Without it, `busAddress`=0x100 and `memMisaligned`=0.
